gat_feat_reader: RTL

Read-back engine on the new-feature output BRAM of the GAT accelerator. After the accelerator finishes, it sweeps every address of the feature BRAM through the `feat_bram_addrb`/`feat_bram_dout` read port. It absorbs the BRAM read latency and re-emits the words as a valid/ready stream for the host/DMA side. It is the consumer counterpart of the feature BRAM write path and sits between `gat_top` and the block-design stream interconnect.

---
 rtl/gat_feat_reader_if.sv | 11 +
 rtl/gat_feat_reader.sv | 94 +++++++++
 2 files changed

// File: rtl/gat_feat_reader_if.sv
// gat_feat_reader_if: valid/ready feature stream from the read-back engine to the host/DMA side
interface gat_feat_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/gat_feat_reader.sv
// gat_feat_reader: sweeps the feature BRAM, absorbs its read latency and re-emits words as a stream
module gat_feat_reader #(
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
  gat_feat_reader_if.master             m,
  output logic                          busy,
  output logic                          done
);
  localparam int IW = NEW_FEATURE_ADDR_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = NUM_FEATURE_OUT > 1 ? $clog2(NUM_FEATURE_OUT) : 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                state, state_nx;
  logic [IW-1:0]         iss_cnt, out_cnt;
  logic [FW-1:0]         feat_cnt;
  logic [RD_LATENCY-1:0] tag_sr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, inflight;
  logic [CW:0]           occ;
  logic                  issue, iss_last, push, pop, clr, last_out;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_sr[i]);
  end
  // credit: a read is only issued if its word is guaranteed a FIFO slot
  assign occ      = {1'b0, inflight} + {1'b0, count};
  assign issue    = state == READ && iss_cnt < IW'(NEW_FEATURE_DEPTH) && occ < (CW+1)'(FIFO_DEPTH);
  assign iss_last = iss_cnt == IW'(NEW_FEATURE_DEPTH - 1);
  assign push     = tag_sr[RD_LATENCY-1];
  assign pop      = m.tvalid && m.tready;
  assign last_out = out_cnt == IW'(NEW_FEATURE_DEPTH - 1);
  assign clr      = state == IDLE && start;
  assign m.tvalid = count != '0;
  assign m.tdata  = m.tvalid ? mem[rd_ptr] : '0;
  assign m.tlast  = m.tvalid && feat_cnt == FW'(NUM_FEATURE_OUT - 1);
  always_comb begin
    state_nx = clr                                 ? READ  :
               state == READ && issue && iss_last  ? DRAIN :
               state == DRAIN && pop && last_out   ? IDLE  : state;
    done     = state == DRAIN && pop && last_out;
    busy     = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_bram_addrb <= '0;
      iss_cnt         <= '0;
      out_cnt         <= '0;
      feat_cnt        <= '0;
      tag_sr          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else if (clr) begin
      iss_cnt  <= '0;
      out_cnt  <= '0;
      feat_cnt <= '0;
      tag_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        feat_bram_addrb <= iss_cnt[NEW_FEATURE_ADDR_W-1:0];
        iss_cnt         <= iss_cnt + IW'(1);
      end
      tag_sr <= (tag_sr << 1) | RD_LATENCY'(issue);
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
        out_cnt  <= out_cnt + IW'(1);
        feat_cnt <= feat_cnt == FW'(NUM_FEATURE_OUT - 1) ? '0 : feat_cnt + FW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= feat_bram_dout;
endmodule
